vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM SRAM arbiter for three requesters.
//
// Requesters (fixed priority screen > ULA+ > CPU):
//   scr_*  screen fetch, always a read   (scr_req/scr_addr -> scr_ack/scr_valid)
//   up_*   ULA+ palette, always a write  (up_req/up_addr/up_wdata -> up_ack)
//   cpu_*  CPU read or write             (cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_valid)
// Shared read data: rdata, qualified by scr_valid / cpu_valid.
// SRAM side: va, vd_i, vd_o, vd_oe, n_vrd, n_vwr (strobes active low).
// busy: high while an access is in progress (FSM not IDLE).
//
// Access timing: IDLE (grant + ack) -> SETUP (1 cycle, strobes high) ->
// STROBE (ACC_CYCLES-1 cycles) -> back to IDLE with valid for reads.
// All SRAM outputs are registered so an asynchronous reset releases the
// strobes immediately.
//
// Optional feature: define VRAM_ARB_STARVE_GUARD_EN to enable the CPU
// starvation guard (CPU promoted after STARVE_MAX lost arbitrations).
module vram_arbiter #(
    parameter int ACC_CYCLES = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        scr_req,
    input  logic [18:0] scr_addr,
    output logic        scr_ack,
    output logic        scr_valid,
    input  logic        up_req,
    input  logic [18:0] up_addr,
    input  logic [7:0]  up_wdata,
    output logic        up_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_valid,
    output logic [7:0]  rdata,
    output logic [18:0] va,
    input  logic [7:0]  vd_i,
    output logic [7:0]  vd_o,
    output logic        vd_oe,
    output logic        n_vrd,
    output logic        n_vwr,
    output logic        busy
);
    if (ACC_CYCLES < 3 || ACC_CYCLES > 15) begin : g_bad_acc
        $error("vram_arbiter: ACC_CYCLES must be 3..15");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("vram_arbiter: STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2} state_t;

    localparam logic [1:0] OWN_SCR = 2'd0;
    localparam logic [1:0] OWN_UP  = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;
    // STROBE lasts ACC_CYCLES-1 cycles; the counter runs down to 0 on the last one.
    localparam logic [3:0] STROBE_LAST = 4'(ACC_CYCLES - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  owner_q, owner_d;
    logic        we_q, we_d;
    logic [18:0] va_q, va_d;
    logic [7:0]  vd_o_q, vd_o_d;
    logic        vd_oe_q, vd_oe_d;
    logic        n_vrd_q, n_vrd_d;
    logic        n_vwr_q, n_vwr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        scr_ack_q, scr_ack_d, up_ack_q, up_ack_d, cpu_ack_q, cpu_ack_d;
    logic        scr_valid_q, scr_valid_d, cpu_valid_q, cpu_valid_d;

    logic        cpu_promote;
    logic        any_req;
    logic [1:0]  win;
    logic        win_we;
    logic [18:0] win_addr;
    logic [7:0]  win_wdata;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;
    assign cpu_promote = cpu_req && (starve_q == STARVE_SAT);
`else
    assign cpu_promote = 1'b0;
`endif

    // Winner selection for an IDLE-cycle grant.
    always_comb begin
        any_req = scr_req | up_req | cpu_req;
        if (cpu_promote)  win = OWN_CPU;
        else if (scr_req) win = OWN_SCR;
        else if (up_req)  win = OWN_UP;
        else              win = OWN_CPU;
        win_we    = (win == OWN_UP) || ((win == OWN_CPU) && cpu_we);
        win_addr  = (win == OWN_SCR) ? scr_addr : (win == OWN_UP) ? up_addr : cpu_addr;
        win_wdata = (win == OWN_UP) ? up_wdata : cpu_wdata;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        va_d        = va_q;
        vd_o_d      = vd_o_q;
        vd_oe_d     = vd_oe_q;
        n_vrd_d     = n_vrd_q;
        n_vwr_d     = n_vwr_q;
        rdata_d     = rdata_q;
        scr_ack_d   = 1'b0;
        up_ack_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        scr_valid_d = 1'b0;
        cpu_valid_d = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = SETUP;
                    owner_d   = win;
                    we_d      = win_we;
                    va_d      = win_addr;
                    vd_oe_d   = win_we;
                    if (win_we) vd_o_d = win_wdata;
                    scr_ack_d = (win == OWN_SCR);
                    up_ack_d  = (win == OWN_UP);
                    cpu_ack_d = (win == OWN_CPU);
`ifdef VRAM_ARB_STARVE_GUARD_EN
                    if (win == OWN_CPU)
                        starve_d = '0;
                    else if (cpu_req && starve_q != STARVE_SAT)
                        starve_d = starve_q + 1'b1;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STROBE_LAST;
                n_vrd_d = we_q;
                n_vwr_d = ~we_q;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    n_vrd_d = 1'b1;
                    n_vwr_d = 1'b1;
                    vd_oe_d = 1'b0;
                    if (!we_q) begin
                        rdata_d     = vd_i;
                        scr_valid_d = (owner_q == OWN_SCR);
                        cpu_valid_d = (owner_q == OWN_CPU);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= OWN_SCR;
            we_q        <= 1'b0;
            va_q        <= '0;
            vd_o_q      <= '0;
            vd_oe_q     <= 1'b0;
            n_vrd_q     <= 1'b1;
            n_vwr_q     <= 1'b1;
            rdata_q     <= '0;
            scr_ack_q   <= 1'b0;
            up_ack_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            scr_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            va_q        <= va_d;
            vd_o_q      <= vd_o_d;
            vd_oe_q     <= vd_oe_d;
            n_vrd_q     <= n_vrd_d;
            n_vwr_q     <= n_vwr_d;
            rdata_q     <= rdata_d;
            scr_ack_q   <= scr_ack_d;
            up_ack_q    <= up_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            scr_valid_q <= scr_valid_d;
            cpu_valid_q <= cpu_valid_d;
`ifdef VRAM_ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign scr_ack   = scr_ack_q;
    assign up_ack    = up_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign scr_valid = scr_valid_q;
    assign cpu_valid = cpu_valid_q;
    assign rdata     = rdata_q;
    assign va        = va_q;
    assign vd_o      = vd_o_q;
    assign vd_oe     = vd_oe_q;
    assign n_vrd     = n_vrd_q;
    assign n_vwr     = n_vwr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a long
// randomized run against a transaction-timeline reference model.
module tb_vram_arbiter;
    localparam int ACC  = 4;
    localparam int SMAX = 8;
    localparam int RN   = 10000;
    localparam int TOT  = RN + 24;
    localparam int AS   = TOT + ACC + 4;

    logic        clk28 = 1'b0;
    logic        rst_n = 1'b0;
    logic        scr_req = 1'b0, up_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [18:0] scr_addr = '0, up_addr = '0, cpu_addr = '0;
    logic [7:0]  up_wdata = '0, cpu_wdata = '0, vd_i = '0;
    logic        scr_ack, scr_valid, up_ack, cpu_ack, cpu_valid;
    logic [7:0]  rdata, vd_o;
    logic [18:0] va;
    logic        vd_oe, n_vrd, n_vwr, busy;

    int checks = 0;
    int errors = 0;

    // Reference-model timeline for the random run (indexed by cycle).
    logic [2:0]  e_ack  [AS];
    logic [1:0]  e_val  [AS];
    logic        e_busy [AS];
    logic        e_rd   [AS];
    logic        e_wr   [AS];
    logic        e_oe   [AS];
    logic [18:0] e_va   [AS];
    logic [7:0]  e_vdo  [AS];
    logic [7:0]  vdi_h  [AS];

    always #5 clk28 = ~clk28;

    vram_arbiter #(.ACC_CYCLES(ACC), .STARVE_MAX(SMAX)) dut (
        .clk28(clk28), .rst_n(rst_n),
        .scr_req(scr_req), .scr_addr(scr_addr), .scr_ack(scr_ack), .scr_valid(scr_valid),
        .up_req(up_req), .up_addr(up_addr), .up_wdata(up_wdata), .up_ack(up_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .rdata(rdata),
        .va(va), .vd_i(vd_i), .vd_o(vd_o), .vd_oe(vd_oe),
        .n_vrd(n_vrd), .n_vwr(n_vwr), .busy(busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk28);
        checks++;
        if ({va, vd_o, rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset_data: va=%h vd_o=%h rdata=%h, required all zero", va, vd_o, rdata);
        end
        checks++;
        if ({vd_oe, n_vrd, n_vwr, busy} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_ctrl: {oe,nrd,nwr,busy}=%b, required 0110", {vd_oe, n_vrd, n_vwr, busy});
        end
        checks++;
        if ({scr_ack, up_ack, cpu_ack, scr_valid, cpu_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: acks/valids=%b, required 00000",
                     {scr_ack, up_ack, cpu_ack, scr_valid, cpu_valid});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk28);
    endtask

    task automatic test_cpu_read();
        int ack_at, nack, val_at, nval, nvrd_lo;
        logic [7:0]  rd;
        logic [18:0] va_s;
        ack_at = -1; nack = 0; val_at = -1; nval = 0; nvrd_lo = 0; rd = '0; va_s = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h12345; vd_i = 8'hA5;
        for (int k = 1; k <= 2 * ACC + 2; k++) begin
            @(negedge clk28);
            if (cpu_ack) begin nack++; ack_at = k; cpu_req = 1'b0; end
            if (!n_vrd) nvrd_lo++;
            if (cpu_valid) begin nval++; val_at = k; rd = rdata; end
            if (k == 3) va_s = va;
        end
        checks++;
        if (ack_at != 1 || nack != 1) begin
            errors++;
            $display("FAIL cpu_read_ack: ack at cycle %0d (count %0d), required cycle 1 (count 1)", ack_at, nack);
        end
        checks++;
        if (nvrd_lo != ACC - 1) begin
            errors++;
            $display("FAIL cpu_read_strobe: n_vrd low %0d cycles, required %0d", nvrd_lo, ACC - 1);
        end
        checks++;
        if (val_at != ACC + 1 || nval != 1) begin
            errors++;
            $display("FAIL cpu_read_latency: valid at cycle %0d (count %0d), required %0d (count 1)",
                     val_at, nval, ACC + 1);
        end
        checks++;
        if (rd !== 8'hA5 || va_s !== 19'h12345) begin
            errors++;
            $display("FAIL cpu_read_data: rdata=%h va=%h, required a5 12345", rd, va_s);
        end
    endtask

    task automatic test_priority();
        int scr_at, up_at, cpu_at;
        logic gap1, gap2;
        scr_at = -1; up_at = -1; cpu_at = -1; gap1 = 1'b1; gap2 = 1'b1;
        scr_req = 1'b1; scr_addr = 19'h00100;
        up_req  = 1'b1; up_addr  = 19'h7FF00; up_wdata = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h04000; cpu_wdata = 8'h22;
        for (int k = 1; k <= 3 * ACC + 6; k++) begin
            @(negedge clk28);
            if (scr_ack) begin scr_at = k; scr_req = 1'b0; end
            if (up_ack)  begin up_at  = k; up_req  = 1'b0; end
            if (cpu_ack) begin cpu_at = k; cpu_req = 1'b0; end
            if (k == ACC + 1)     gap1 = busy;
            if (k == 2 * ACC + 2) gap2 = busy;
        end
        checks++;
        if (scr_at != 1 || up_at != ACC + 2 || cpu_at != 2 * ACC + 3) begin
            errors++;
            $display("FAIL priority_order: acks scr=%0d up=%0d cpu=%0d, required 1 %0d %0d",
                     scr_at, up_at, cpu_at, ACC + 2, 2 * ACC + 3);
        end
        checks++;
        if (gap1 !== 1'b0 || gap2 !== 1'b0) begin
            errors++;
            $display("FAIL priority_idle_gap: busy in gap cycles=%b%b, required 00", gap1, gap2);
        end
    endtask

    task automatic test_up_write();
        int ack_at, oe_cnt, nvwr_lo, nvrd_lo, nval;
        logic oe_setup;
        logic [18:0] va_s;
        logic [7:0]  vdo_s;
        ack_at = -1; oe_cnt = 0; nvwr_lo = 0; nvrd_lo = 0; nval = 0;
        oe_setup = 1'b0; va_s = '0; vdo_s = '0;
        up_req = 1'b1; up_addr = 19'h7FFC0; up_wdata = 8'h3C;
        for (int k = 1; k <= ACC + 4; k++) begin
            @(negedge clk28);
            if (up_ack) begin ack_at = k; up_req = 1'b0; end
            if (vd_oe) oe_cnt++;
            if (!n_vwr) nvwr_lo++;
            if (!n_vrd) nvrd_lo++;
            if (scr_valid || cpu_valid) nval++;
            if (k == 1) oe_setup = vd_oe && n_vwr;
            if (k == 3) begin va_s = va; vdo_s = vd_o; end
        end
        checks++;
        if (ack_at != 1 || oe_cnt != ACC || !oe_setup) begin
            errors++;
            $display("FAIL up_write_oe: ack=%0d oe_cycles=%0d setup_oe=%b, required 1 %0d 1",
                     ack_at, oe_cnt, oe_setup, ACC);
        end
        checks++;
        if (nvwr_lo != ACC - 1 || nvrd_lo != 0 || nval != 0) begin
            errors++;
            $display("FAIL up_write_strobe: nwr_lo=%0d nrd_lo=%0d valids=%0d, required %0d 0 0",
                     nvwr_lo, nvrd_lo, nval, ACC - 1);
        end
        checks++;
        if (va_s !== 19'h7FFC0 || vdo_s !== 8'h3C) begin
            errors++;
            $display("FAIL up_write_bus: va=%h vd_o=%h, required 7ffc0 3c", va_s, vdo_s);
        end
    endtask

    task automatic test_starve();
        int scr_acks, cpu_arb;
        scr_acks = 0; cpu_arb = -1;
        scr_req = 1'b1; scr_addr = 19'h00200;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h05000; cpu_wdata = 8'h77;
        for (int k = 1; k <= 15 * (ACC + 1) + 3; k++) begin
            @(negedge clk28);
            if (scr_ack) scr_acks++;
            if (cpu_ack && cpu_arb < 0) begin cpu_arb = scr_acks + 1; cpu_req = 1'b0; end
        end
        scr_req = 1'b0; cpu_req = 1'b0;
        repeat (ACC + 3) @(negedge clk28);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        checks++;
        if (cpu_arb != SMAX + 1) begin
            errors++;
            $display("FAIL starve_guard: cpu won arbitration %0d, required %0d", cpu_arb, SMAX + 1);
        end
`else
        checks++;
        if (cpu_arb != -1 || scr_acks < 12) begin
            errors++;
            $display("FAIL starve_fixed: cpu won arbitration %0d after %0d screen grants, required never (-1)",
                     cpu_arb, scr_acks);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic mid_ok, any_val, any_busy;
        mid_ok = 1'b0; any_val = 1'b0; any_busy = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h0ABCD; cpu_wdata = 8'h5A;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk28);
            if (cpu_ack) cpu_req = 1'b0;
            if (k == 3) mid_ok = !n_vwr && vd_oe;
        end
        checks++;
        if (!mid_ok) begin
            errors++;
            $display("FAIL reset_mid_pre: n_vwr=%b vd_oe=%b in strobe, required 0 1", n_vwr, vd_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({n_vwr, n_vrd, vd_oe, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid_async: {nwr,nrd,oe,busy}=%b, required 1100", {n_vwr, n_vrd, vd_oe, busy});
        end
        @(negedge clk28);
        rst_n = 1'b1;
        for (int k = 1; k <= ACC + 3; k++) begin
            @(negedge clk28);
            if (cpu_valid || scr_valid) any_val = 1'b1;
            if (busy) any_busy = 1'b1;
        end
        checks++;
        if (any_val || any_busy) begin
            errors++;
            $display("FAIL reset_mid_after: valid_seen=%b busy_seen=%b, required 0 0", any_val, any_busy);
        end
    endtask

    task automatic test_random();
        int free_at, starve, w, nreads, nvals, prints;
        logic we;
        logic [18:0] addr, model_va;
        logic [7:0]  data, model_rd;
        logic [2:0]  g_ack;
        logic [1:0]  g_val;
        logic [55:0] got, expv;
        free_at = 0; starve = 0; nreads = 0; nvals = 0; prints = 0;
        model_va = '0; model_rd = '0;
        for (int i = 0; i < AS; i++) begin
            e_ack[i] = '0; e_val[i] = '0; e_busy[i] = 1'b0; e_rd[i] = 1'b0;
            e_wr[i] = 1'b0; e_oe[i] = 1'b0; e_va[i] = '0; e_vdo[i] = '0; vdi_h[i] = '0;
        end
        scr_req = 1'b0; up_req = 1'b0; cpu_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk28);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < TOT; cyc++) begin
            @(negedge clk28);
            // --- compare this cycle against the model timeline
            if (e_busy[cyc]) model_va = e_va[cyc];
            if (e_val[cyc] != 2'b00) model_rd = vdi_h[cyc - 1];
            if (scr_valid || cpu_valid) nvals++;
            g_ack = {scr_ack, up_ack, cpu_ack};
            g_val = {scr_valid, cpu_valid};
            got  = {g_ack, g_val, busy, n_vrd, n_vwr, vd_oe, va, rdata, 19'h0};
            expv = {e_ack[cyc], e_val[cyc], e_busy[cyc], !e_rd[cyc], !e_wr[cyc], e_oe[cyc],
                    model_va, model_rd, 19'h0};
            checks++;
            if (got !== expv) begin
                errors++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random_cycle %0d: got ack=%b val=%b busy=%b nrd=%b nwr=%b oe=%b va=%h rd=%h, required ack=%b val=%b busy=%b nrd=%b nwr=%b oe=%b va=%h rd=%h",
                             cyc, g_ack, g_val, busy, n_vrd, n_vwr, vd_oe, va, rdata,
                             e_ack[cyc], e_val[cyc], e_busy[cyc], !e_rd[cyc], !e_wr[cyc], e_oe[cyc],
                             model_va, model_rd);
                end
            end
            if (e_oe[cyc]) begin
                checks++;
                if (vd_o !== e_vdo[cyc]) begin
                    errors++;
                    if (prints < 10) begin
                        prints++;
                        $display("FAIL random_vd_o cycle %0d: got %h required %h", cyc, vd_o, e_vdo[cyc]);
                    end
                end
            end
            checks++;
            if ((!n_vrd && !n_vwr) || (vd_oe && !n_vrd)) begin
                errors++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random_bus_invariant cycle %0d: nrd=%b nwr=%b oe=%b, required no overlap",
                             cyc, n_vrd, n_vwr, vd_oe);
                end
            end
            // --- drive inputs for the next edge
            if (cyc < RN) begin
                scr_req = ($urandom_range(0, 3) == 0);
                up_req  = ($urandom_range(0, 3) == 0);
                cpu_req = ($urandom_range(0, 2) == 0);
            end else begin
                scr_req = 1'b0; up_req = 1'b0; cpu_req = 1'b0;
            end
            scr_addr  = 19'($urandom);
            up_addr   = 19'($urandom);
            cpu_addr  = 19'($urandom);
            up_wdata  = 8'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_we    = 1'($urandom);
            vd_i      = 8'($urandom);
            vdi_h[cyc] = vd_i;
            // --- model: an access granted now occupies the next ACC cycles
            if (cyc >= free_at && (scr_req || up_req || cpu_req)) begin
                w = 2;
`ifdef VRAM_ARB_STARVE_GUARD_EN
                if (cpu_req && starve == SMAX) w = 2;
                else if (scr_req) w = 0;
                else if (up_req) w = 1;
                if (w == 2) starve = 0;
                else if (cpu_req && starve < SMAX) starve++;
`else
                if (scr_req) w = 0;
                else if (up_req) w = 1;
`endif
                we   = (w == 1) || (w == 2 && cpu_we);
                addr = (w == 0) ? scr_addr : (w == 1) ? up_addr : cpu_addr;
                data = (w == 1) ? up_wdata : cpu_wdata;
                e_ack[cyc + 1] = (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : 3'b001;
                for (int k = 1; k <= ACC; k++) begin
                    e_busy[cyc + k] = 1'b1;
                    e_va[cyc + k]   = addr;
                    if (we) begin e_oe[cyc + k] = 1'b1; e_vdo[cyc + k] = data; end
                    if (k >= 2) begin
                        if (we) e_wr[cyc + k] = 1'b1;
                        else    e_rd[cyc + k] = 1'b1;
                    end
                end
                if (!we) begin
                    e_val[cyc + ACC + 1] = (w == 0) ? 2'b10 : 2'b01;
                    nreads++;
                end
                free_at = cyc + ACC + 1;
            end
        end
        checks++;
        if (nvals != nreads || nreads == 0) begin
            errors++;
            $display("FAIL random_read_count: valids=%0d, required %0d read grants", nvals, nreads);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_priority();
        test_up_write();
        test_starve();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
